// File: rtl/seg7_reader.sv
// seg7_reader: recovers hex nibbles from a sampled, active-low 7-segment
// pattern. A pattern has to be seen on STABLE_CYCLES consecutive samples
// before it is accepted. Accepted digits are emitted on a valid/ready port.
// Repeats of the same digit are suppressed until a blank is accepted.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [0:6] seg_in,
   input  logic       sample_en,
   input  logic       ready,
   input  logic       clr_flags,
   output logic [3:0] data,
   output logic       valid,
   output logic       blank,
   output logic       err,
   output logic       overrun
);

   localparam logic [4:0] STABLE = 5'(STABLE_CYCLES);
   localparam logic [0:6] ALL_OFF = 7'b1111111;

   typedef enum logic [1:0] {IDLE, QUAL, LOCK} state_t;

   state_t     state, state_nxt;
   logic [0:6] cand, cand_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [4:0] cnt_inc;
   logic       accept;

   logic [3:0] last_nib;
   logic       last_vld;
   logic [4:0] dec;
   logic       is_hit, is_blank, emit, take, err_set, ovr_set;

   // Pattern table: {hit, nibble}; hit=0 for anything outside the table.
   function automatic logic [4:0] decode(input logic [0:6] p);
      case (p)
         7'b0000001: decode = 5'h10;
         7'b1001111: decode = 5'h11;
         7'b0010010: decode = 5'h12;
         7'b0000110: decode = 5'h13;
         7'b1001100: decode = 5'h14;
         7'b0100100: decode = 5'h15;
         7'b0100000: decode = 5'h16;
         7'b0001101: decode = 5'h17;
         7'b0000000: decode = 5'h18;
         7'b0001100: decode = 5'h19;
         7'b0001000: decode = 5'h1A;
         7'b1100000: decode = 5'h1B;
         7'b0110001: decode = 5'h1C;
         7'b1000010: decode = 5'h1D;
         7'b0110000: decode = 5'h1E;
         7'b0111000: decode = 5'h1F;
         default:    decode = 5'h00;
      endcase
   endfunction

   assign cnt_inc = {1'b0, cnt} + 5'd1;

   // Qualifier state register: state, candidate pattern and stability count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cand  <= ALL_OFF;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cand  <= cand_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Qualifier next state. Only enabled samples move it. A changed pattern
   // restarts the count. The accept happens on the sample that brings the
   // count up to STABLE_CYCLES.
   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      if (sample_en) begin
         if (seg_in != cand) begin
            cand_nxt = seg_in;
            cnt_nxt  = 4'd1;
            if (STABLE == 5'd1) begin
               accept    = 1'b1;
               state_nxt = LOCK;
            end else begin
               state_nxt = QUAL;
            end
         end else if (state == QUAL) begin
            if (cnt_inc >= STABLE) begin
               cnt_nxt   = STABLE[3:0];
               accept    = 1'b1;
               state_nxt = LOCK;
            end else begin
               cnt_nxt = cnt_inc[3:0];
            end
         end
      end
   end

   // The accepted pattern is always the current sample, because the
   // candidate is either equal to it or is loaded from it.
   always_comb begin
      dec      = decode(seg_in);
      is_hit   = dec[4];
      is_blank = (seg_in == ALL_OFF);
      emit     = accept && is_hit && (!last_vld || dec[3:0] != last_nib);
      take     = emit && (!valid || ready);
      ovr_set  = emit && !take;
      err_set  = accept && !is_hit && !is_blank;
   end

   // Output register, last-emitted tracking and sticky flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data     <= 4'd0;
         valid    <= 1'b0;
         blank    <= 1'b0;
         err      <= 1'b0;
         overrun  <= 1'b0;
         last_nib <= 4'd0;
         last_vld <= 1'b0;
      end else begin
         if (take) begin
            data     <= dec[3:0];
            valid    <= 1'b1;
            last_nib <= dec[3:0];
            last_vld <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         if (accept && is_blank) begin
            blank    <= 1'b1;
            last_vld <= 1'b0;
         end else if (accept && is_hit) begin
            blank <= 1'b0;
         end
         err     <= err_set | (err & ~clr_flags);
         overrun <= ovr_set | (overrun & ~clr_flags);
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader. Expected values are hand-derived from the
// decode table and the qualify/emit rules.
module tb_seg7_reader;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [0:6] seg_in = 7'b1111111;
   logic       sample_en = 1'b0;
   logic       ready = 1'b1;
   logic       clr_flags = 1'b0;
   logic [3:0] data, data1;
   logic       valid, blank, err, overrun;
   logic       valid1, blank1, err1, overrun1;

   int n_pass = 0;
   int n_total = 0;
   int vcnt = 0;

   localparam logic [0:6] P0 = 7'b0000001, P2 = 7'b0010010, P3 = 7'b0000110,
                          P4 = 7'b1001100, P5 = 7'b0100100, PA = 7'b0001000,
                          PB = 7'b1100000, PC = 7'b0110001, PE = 7'b0110000,
                          PF = 7'b0111000, PBL = 7'b1111111, PBAD = 7'b1111110;

   seg7_reader #(.STABLE_CYCLES(4)) dut (
      .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .sample_en(sample_en),
      .ready(ready), .clr_flags(clr_flags), .data(data), .valid(valid),
      .blank(blank), .err(err), .overrun(overrun)
   );

   seg7_reader #(.STABLE_CYCLES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .sample_en(sample_en),
      .ready(ready), .clr_flags(clr_flags), .data(data1), .valid(valid1),
      .blank(blank1), .err(err1), .overrun(overrun1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   // n enabled samples of pattern p; vcnt counts cycles that end with valid=1
   task automatic smp(input logic [0:6] p, input int n);
      for (int i = 0; i < n; i++) begin
         seg_in = p;
         sample_en = 1'b1;
         @(posedge clk); #1;
         if (valid) vcnt++;
      end
      sample_en = 1'b0;
   endtask

   task automatic idle(input int n);
      sample_en = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      // reset state
      ready = 1'b1;
      sample_en = 1'b1;
      clr_flags = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      sample_en = 1'b0;
      clr_flags = 1'b0;
      chk("rst_out", {data, valid, blank, err, overrun}, 8'h00);
      reset_n = 1'b1;

      // stable 2 accepted after 4 samples, single pulse, no re-emit
      smp(P2, 3);
      chk("q3_valid", valid, 1'b0);
      smp(P2, 1);
      chk("q4_valid", valid, 1'b1);
      chk("q4_data", data, 4'h2);
      vcnt = 0;
      smp(P2, 10);
      chk("lock_no_reemit", vcnt, 0);

      // short 3 is never emitted, 4 is
      vcnt = 0;
      smp(P3, 3);
      smp(P4, 4);
      chk("only4_cnt", vcnt, 1);
      chk("only4_data", data, 4'h4);
      idle(1);
      chk("only4_drop", valid, 1'b0);

      // overrun with ready low, then clear
      ready = 1'b0;
      smp(PA, 4);
      chk("ovr_a_data", data, 4'hA);
      smp(PB, 4);
      chk("ovr_flag", overrun, 1'b1);
      chk("ovr_keep", {valid, data}, 5'h1A);
      clr_flags = 1'b1;
      idle(1);
      clr_flags = 1'b0;
      chk("ovr_clr", overrun, 1'b0);
      chk("ovr_clr_data", {valid, data}, 5'h1A);
      ready = 1'b1;
      idle(1);
      chk("xfer_drop", valid, 1'b0);

      // blank forgets the last digit, an unknown pattern flags err
      smp(P0, 4);
      chk("d0_first", {valid, data, blank}, 6'h20);
      idle(1);
      smp(PBL, 4);
      chk("blank_set", {valid, blank}, 2'b01);
      smp(P0, 4);
      chk("d0_again", {valid, data, blank}, 6'h20);
      idle(1);
      smp(PBAD, 4);
      chk("err_set", {err, valid, blank}, 3'b100);
      clr_flags = 1'b1;
      idle(1);
      clr_flags = 1'b0;
      chk("err_clr", err, 1'b0);

      // emit coincident with a transfer keeps valid high, no overrun
      ready = 1'b0;
      smp(P5, 4);
      chk("pre_c_valid", {valid, data}, 5'h15);
      smp(PC, 3);
      ready = 1'b1;
      smp(PC, 1);
      chk("c_same_cycle", {valid, data, overrun}, 6'h38);

      // enabled samples only on every other cycle
      do_reset();
      for (int i = 0; i < 8; i++) begin
         seg_in = PF;
         sample_en = (i % 2 == 1);
         @(posedge clk); #1;
         if (i == 6) chk("tog_c7", valid, 1'b0);
      end
      sample_en = 1'b0;
      chk("tog_c8", {valid, data}, 5'h1F);

      // reset mid-qualification clears everything and restarts the count
      smp(PE, 2);
      do_reset();
      chk("mid_rst", {data, valid, blank, err, overrun}, 8'h00);
      smp(PE, 1);
      chk("sc1_same_cycle", {valid1, data1}, 5'h1E);
      smp(PE, 2);
      chk("rst_cnt3", valid, 1'b0);
      smp(PE, 1);
      chk("rst_cnt4", {valid, data}, 5'h1E);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 STABLE_CYCLES, default 4, number of consecutive identical samples needed to accept a pattern (legal range 1..15).
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET_N  input  1  reset, synchronous and active-low.
REQ-004 SEG_IN  input  7 [0:6]  sampled segment pattern, active-low, bit 0 = seg a through bit 6 = seg g.
REQ-005 SAMPLE_EN  input  1  qualifies SEG_IN as a sample in this cycle.
REQ-006 DATA  output  4  recovered hex nibble.
REQ-007 VALID  output  1  DATA holds an untransferred nibble.
REQ-008 READY  input  1  consumer accepts DATA when VALID=1.
REQ-009 BLANK  output  1  last accepted pattern was all-off (1111111).
REQ-010 ERR  output  1  sticky; a stable pattern that is neither a table entry nor blank was accepted.
REQ-011 OVERRUN  output  1  sticky; a new nibble was dropped because VALID=1 and READY=0.
REQ-012 CLR_FLAGS  input  1  clears ERR and OVERRUN.

Function
REQ-013 Decode table (SEG_IN [0:6] -> DATA) SHALL be exactly: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001101->7, 0000000->8, 0001100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-014 Sample cycles (SAMPLE_EN=1) SHALL be the only cycles that advance the qualifier; with SAMPLE_EN=0 candidate, counter and state hold.
REQ-015 State machine SHALL have states IDLE (no candidate), QUAL (counting), LOCK (candidate accepted, waiting for change).
REQ-016 Sample differing from the candidate register (any state) SHALL load it as candidate, set count=1, go to QUAL.
REQ-017 Sample equal to the candidate in QUAL SHALL increment count; count saturates at STABLE_CYCLES.
REQ-018 The sample at which count reaches STABLE_CYCLES SHALL "accept" the candidate and go to LOCK; equal samples in LOCK cause no further accept.
REQ-019 With STABLE_CYCLES=1 a differing sample SHALL be accepted in the same cycle it is loaded.
REQ-020 Accept of a table pattern whose nibble differs from the last emitted nibble, or when no nibble is recorded, SHALL emit it: DATA and VALID update at the next edge (latency 1 cycle from accepting sample); BLANK cleared.
REQ-021 Accept of a table pattern equal to the last emitted nibble SHALL emit nothing and clear BLANK.
REQ-022 Accept of 1111111 SHALL set BLANK, forget last emitted nibble (same digit after blank re-emits), emit nothing.
REQ-023 Accept of any other pattern SHALL set ERR, leave BLANK, DATA, VALID and last emitted nibble unchanged.
REQ-024 Transfer occurs when VALID=1 and READY=1; VALID clears next edge; DATA holds last value.
REQ-025 Emit in the same cycle as a transfer SHALL load new DATA and keep VALID=1, no OVERRUN.
REQ-026 Emit while VALID=1 and READY=0 SHALL drop the nibble, keep DATA, set OVERRUN; dropped nibble is not recorded as last emitted.
REQ-027 CLR_FLAGS SHALL clear ERR and OVERRUN next edge; a set event in the same cycle wins.
REQ-028 READY with VALID=0 SHALL have no effect.

Reset
REQ-029 RESET_N=0 at an edge SHALL force state IDLE, candidate=1111111, count=0, no last nibble, DATA=0, VALID=0, BLANK=0, ERR=0, OVERRUN=0, regardless of any other input.
REQ-030 Reset mid-qualification or with VALID=1 SHALL discard the candidate and pending DATA; first post-reset acceptance follows REQ-016..023 normally.

Verification
REQ-031 STABLE_CYCLES=4, READY=1, SEG_IN=0010010 for 4 samples -> VALID=1, DATA=2 one cycle after 4th sample, VALID low next cycle; 10 further samples -> no re-emit.
REQ-032 SEG_IN 0000110 x3, 1001100 x4 -> only DATA=4 emitted; 3 never emitted.
REQ-033 READY=0; accept 0001000 then 1100000 -> DATA=A, VALID=1, OVERRUN=1; CLR_FLAGS -> OVERRUN=0, DATA still A.
REQ-034 Accept 0000001, 1111111, 0000001 -> DATA=0 emitted twice, BLANK=1 between; accept 1111110 -> ERR=1, no VALID.
REQ-035 SAMPLE_EN toggling every other cycle with stable 0111000 -> emit after 4th enabled sample (cycle 8); RESET_N=0 after 2 samples -> all outputs 0, count restarts.
REQ-036 VALID=1, READY=1 in the cycle a new nibble C is accepted -> VALID stays 1, DATA=C, OVERRUN=0.
